// File: rtl/pipeline_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipeline_pkg : shared types and constants for the memory/writeback stage
// Revision     : 1.0
// ----------------------------------------------------------------------------
package pipeline_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

    localparam logic [31:0] DEFAULT_ADDR_OFFSET = 32'd1024;
    localparam logic [3:0]  REG_PC              = 4'hF;

    // Byte address to word index; the two low bits drop out, so misaligned
    // addresses simply round down.
    function automatic logic [31:0] word_index(input logic [31:0] byte_addr,
                                               input logic [31:0] offset);
        return (byte_addr - offset) >> 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wb_reg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_wb_reg : MEM/WB pipeline register with bubble insertion; writes to r15 are dropped
// Revision   : 1.0
// ----------------------------------------------------------------------------
module mem_wb_reg
    import pipeline_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        bubble,
    input  logic        en_in,
    input  logic [3:0]  dest_in,
    input  logic [31:0] result_in,
    output logic        wb_en,
    output logic [3:0]  wb_dest,
    output logic [31:0] wb_result
);

    logic        r_en;
    logic [3:0]  r_dest;
    logic [31:0] r_result;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_en     <= 1'b0;
            r_dest   <= 4'd0;
            r_result <= 32'd0;
        end else if (load) begin
            // The register file has no r15, so that index never gets an enable.
            r_en     <= en_in & (dest_in != REG_PC);
            r_dest   <= dest_in;
            r_result <= result_in;
        end else if (bubble) begin
            r_en     <= 1'b0;
        end
    end

    assign wb_en     = r_en;
    assign wb_dest   = r_dest;
    assign wb_result = r_result;

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_wb_stage : load/store handshake with timeout, plus the MEM/WB register
// Revision     : 1.0
// ----------------------------------------------------------------------------
module mem_wb_stage
    import pipeline_pkg::*;
#(
    parameter logic [31:0] ADDR_OFFSET = DEFAULT_ADDR_OFFSET,
    parameter int unsigned MEM_AW      = 8,
    parameter int unsigned TIMEOUT     = 16
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              ex_mem_r_en,
    input  logic              ex_mem_w_en,
    input  logic              ex_wb_en,
    input  logic [3:0]        ex_dest,
    input  logic [31:0]       ex_alu_res,
    input  logic [31:0]       ex_store_val,
    output logic              mem_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic              mem_err,
    output logic              wb_en,
    output logic [3:0]        wb_dest,
    output logic [31:0]       wb_result
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mem_state_t        r_state;
    logic              r_req;
    logic              r_we;
    logic [MEM_AW-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err;

    mem_state_t        w_state_next;
    logic              w_req_next;
    logic              w_we_next;
    logic [MEM_AW-1:0] w_addr_next;
    logic [31:0]       w_wdata_next;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_err_next;
    logic              w_wb_load;
    logic [31:0]       w_wb_result;

    logic              w_memop;
    logic              w_timeout_hit;
    logic [MEM_AW-1:0] w_word_addr;

    assign w_memop       = ex_valid & (ex_mem_r_en | ex_mem_w_en);
    assign w_timeout_hit = (r_cnt == CNT_LAST);
    assign w_word_addr   = MEM_AW'(word_index(ex_alu_res, ADDR_OFFSET));

    // Upstream is released in the same cycle the access finishes or aborts.
    assign mem_stall = w_memop & ~((r_state == ACCESS) & (mem_ready | w_timeout_hit));

    always_comb begin
        w_state_next = r_state;
        w_req_next   = r_req;
        w_we_next    = r_we;
        w_addr_next  = r_addr;
        w_wdata_next = r_wdata;
        w_cnt_next   = r_cnt;
        w_err_next   = 1'b0;
        w_wb_load    = 1'b0;
        w_wb_result  = ex_alu_res;

        case (r_state)
            IDLE: begin
                if (w_memop) begin
                    w_state_next = ACCESS;
                    w_req_next   = 1'b1;
                    w_we_next    = ex_mem_w_en;
                    w_addr_next  = w_word_addr;
                    w_wdata_next = ex_store_val;
                    w_cnt_next   = '0;
                end else if (ex_valid) begin
                    w_wb_load = 1'b1;
                end
            end
            ACCESS: begin
                w_cnt_next  = r_cnt + 1'b1;
                w_wb_result = mem_rdata;
                if (mem_ready) begin
                    w_state_next = IDLE;
                    w_req_next   = 1'b0;
                    w_wb_load    = ex_mem_r_en;
                end else if (w_timeout_hit) begin
                    w_state_next = IDLE;
                    w_req_next   = 1'b0;
                    w_err_next   = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_req_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_req   <= w_req_next;
            r_we    <= w_we_next;
            r_addr  <= w_addr_next;
            r_wdata <= w_wdata_next;
            r_cnt   <= w_cnt_next;
            r_err   <= w_err_next;
        end
    end

    // Anything that is not a completing writeback is a bubble, so a stalled
    // instruction never writes the register file twice.
    mem_wb_reg u_mem_wb_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (w_wb_load),
        .bubble    (~w_wb_load),
        .en_in     (ex_wb_en),
        .dest_in   (ex_dest),
        .result_in (w_wb_result),
        .wb_en     (wb_en),
        .wb_dest   (wb_dest),
        .wb_result (wb_result)
    );

    assign mem_req   = r_req;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_wb_stage : directed table plus randomized instruction stream for mem_wb_stage
// Revision        : 1.0
// ----------------------------------------------------------------------------
module tb_mem_wb_stage;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_mem_r_en, ex_mem_w_en, ex_wb_en;
    logic [3:0]  ex_dest;
    logic [31:0] ex_alu_res, ex_store_val;
    logic        mem_stall, mem_req, mem_we, mem_ready, mem_err;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        wb_en;
    logic [3:0]  wb_dest;
    logic [31:0] wb_result;

    always #5 clk = ~clk;

    mem_wb_stage #(.ADDR_OFFSET(32'd1024), .MEM_AW(8), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_mem_r_en(ex_mem_r_en), .ex_mem_w_en(ex_mem_w_en),
        .ex_wb_en(ex_wb_en), .ex_dest(ex_dest), .ex_alu_res(ex_alu_res),
        .ex_store_val(ex_store_val), .mem_stall(mem_stall), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_err(mem_err),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_result(wb_result)
    );

    typedef struct {
        logic        valid, rd, wr, wbe, noise;
        logic [3:0]  dest;
        logic [31:0] alu, sv, rdata;
        int          lat;       // ACCESS cycle in which memory answers
        int          exp_n;     // expected stall cycles == request cycles
        logic [7:0]  exp_addr;
        logic        exp_wr;
        logic [31:0] exp_res;
        logic        exp_err;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [3:0]  dest;
        logic [31:0] res;
    } wb_t;

    wb_t  exp_q[$];
    wb_t  mon_e;
    vec_t vt[12];
    int   total = 0, bad = 0, cyc = 0, err_seen = 0, err_exp = 0;
    bit   mon_on = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Register-file write scoreboard: every write must match the next expected one, on time.
    always @(negedge clk) begin
        if (mon_on) begin
            if (wb_en) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL wb_unexpected actual dest=%0d res=%0h required no write", wb_dest, wb_result);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.cyc != cyc || mon_e.dest !== wb_dest || mon_e.res !== wb_result) begin
                        bad++;
                        $display("FAIL wb_write actual cyc=%0d dest=%0d res=%0h required cyc=%0d dest=%0d res=%0h",
                                 cyc, wb_dest, wb_result, mon_e.cyc, mon_e.dest, mon_e.res);
                    end
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                total++;
                bad++;
                $display("FAIL wb_missing actual no write required dest=%0d res=%0h", exp_q[0].dest, exp_q[0].res);
                void'(exp_q.pop_front());
            end
            if (mem_err) err_seen++;
        end
    end

    function automatic vec_t mk(logic valid, logic rd, logic wr, logic wbe, logic [3:0] dest,
                                logic [31:0] alu, logic [31:0] sv, logic [31:0] rdata, int lat,
                                int exp_n, logic [7:0] exp_addr, logic exp_wr,
                                logic [31:0] exp_res, logic exp_err);
        vec_t v;
        v.valid = valid; v.rd = rd; v.wr = wr; v.wbe = wbe; v.noise = 1'b0;
        v.dest = dest; v.alu = alu; v.sv = sv; v.rdata = rdata; v.lat = lat;
        v.exp_n = exp_n; v.exp_addr = exp_addr; v.exp_wr = exp_wr;
        v.exp_res = exp_res; v.exp_err = exp_err;
        return v;
    endfunction

    // Reference model: expectations follow directly from the instruction kind
    // and the memory's answer latency.
    function automatic vec_t rand_vec();
        vec_t v;
        int   kind;
        logic memop;
        kind    = $urandom_range(0, 3);
        v.valid = (kind != 0);
        v.rd    = (kind == 2) || (kind == 0 && $urandom_range(0, 1) == 1);
        v.wr    = (kind == 3);
        v.wbe   = 1'($urandom);
        v.noise = 1'($urandom);
        v.dest  = 4'($urandom);
        v.alu   = $urandom;
        v.sv    = $urandom;
        v.rdata = $urandom;
        v.lat   = $urandom_range(1, 20);
        memop     = v.valid && (v.rd || v.wr);
        v.exp_n   = memop ? ((v.lat < TIMEOUT) ? v.lat : TIMEOUT) : 0;
        v.exp_addr = 8'((v.alu - 32'd1024) >> 2);
        v.exp_err = memop && (v.lat > TIMEOUT);
        v.exp_wr  = v.valid && v.wbe && (v.dest != 4'hF) &&
                    (!memop || (v.rd && v.lat <= TIMEOUT));
        v.exp_res = memop ? v.rdata : v.alu;
        return v;
    endfunction

    task automatic run_instr(input vec_t v);
        int acc    = 0;
        int stalls = 0;
        bit done   = 0;
        bit hit;
        ex_valid = v.valid; ex_mem_r_en = v.rd; ex_mem_w_en = v.wr; ex_wb_en = v.wbe;
        ex_dest = v.dest; ex_alu_res = v.alu; ex_store_val = v.sv;
        if (v.exp_wr && !(v.valid && (v.rd || v.wr)))
            exp_q.push_back('{cyc + 1, v.dest, v.exp_res});
        if (v.exp_err) err_exp++;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            hit = 1'b0;
            if (mem_req) begin
                acc++;
                hit = (acc == v.lat);
                chk("mem_addr", 96'(mem_addr), 96'(v.exp_addr));
                chk("mem_we", 96'(mem_we), 96'(v.wr));
                if (v.wr) chk("mem_wdata", 96'(mem_wdata), 96'(v.sv));
            end
            mem_ready = mem_req ? hit : v.noise;
            mem_rdata = hit ? v.rdata : $urandom;
            #1;
            if (mem_stall) stalls++;
            else done = 1;
            if (hit && v.exp_wr) exp_q.push_back('{cyc + 1, v.dest, v.exp_res});
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b0;
        chk("instr_completes", 96'(done), 96'(1));
        chk("stall_cycles", 96'(stalls), 96'(v.exp_n));
        chk("request_cycles", 96'(acc), 96'(v.exp_n));
    endtask

    initial begin
        rst = 1'b0;
        ex_valid = 0; ex_mem_r_en = 0; ex_mem_w_en = 0; ex_wb_en = 0;
        ex_dest = 0; ex_alu_res = 0; ex_store_val = 0; mem_ready = 0; mem_rdata = 0;

        //         v  rd wr wbe dest alu           sv       rdata          lat n   addr wr res            err
        vt[0]  = mk(1, 0, 0, 1,  3,  32'h55,       0,       0,             0,  0,  0,   1, 32'h55,        0);
        vt[1]  = mk(1, 1, 0, 1,  5,  32'd1032,     0,       32'hDEAD,      1,  1,  2,   1, 32'hDEAD,      0);
        vt[2]  = mk(1, 0, 1, 0,  6,  32'd1028,     32'd7,   0,             3,  3,  1,   0, 0,             0);
        vt[3]  = mk(1, 1, 0, 1,  7,  32'd2000,     0,       32'h1111,      99, 16, 244, 0, 0,             1);
        vt[4]  = mk(1, 0, 0, 1,  15, 32'h1234,     0,       0,             0,  0,  0,   0, 0,             0);
        vt[5]  = mk(1, 1, 0, 1,  2,  32'd1036,     0,       32'hCAFEF00D,  2,  2,  3,   1, 32'hCAFEF00D,  0);
        vt[6]  = mk(1, 0, 0, 0,  9,  32'h77,       0,       0,             0,  0,  0,   0, 0,             0);
        vt[7]  = mk(0, 1, 0, 1,  8,  32'd1040,     0,       0,             0,  0,  0,   0, 0,             0);
        vt[8]  = mk(1, 1, 0, 1,  4,  32'd1027,     0,       32'h0BADBEEF,  16, 16, 0,   1, 32'h0BADBEEF,  0);
        vt[9]  = mk(1, 0, 1, 1,  10, 32'd2224,     32'hA5A5, 0,            17, 16, 44,  0, 0,             1);
        vt[10] = mk(1, 1, 0, 1,  15, 32'd1044,     0,       32'h99,        1,  1,  5,   0, 0,             0);
        vt[11] = mk(1, 0, 0, 1,  0,  32'hFFFFFFFF, 0,       0,             0,  0,  0,   1, 32'hFFFFFFFF,  0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 96'({mem_req, mem_we, mem_err, wb_en, mem_addr, mem_wdata, wb_dest, wb_result}), 96'(0));
        chk("reset_stall", 96'(mem_stall), 96'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        mon_on = 1'b1;

        for (int i = 0; i < 12; i++) run_instr(vt[i]);

        // Reset while a load is waiting on memory: the access is abandoned.
        ex_valid = 1; ex_mem_r_en = 1; ex_mem_w_en = 0; ex_wb_en = 1;
        ex_dest = 4'd1; ex_alu_res = 32'd1100; mem_ready = 0;
        repeat (3) begin @(posedge clk); #1; end
        chk("req_before_reset", 96'(mem_req), 96'(1));
        rst = 1'b0;
        ex_valid = 0;
        @(posedge clk);
        #1;
        chk("outputs_after_midreset", 96'({mem_req, mem_we, mem_err, wb_en, mem_addr, mem_wdata, wb_dest, wb_result}), 96'(0));
        rst = 1'b1;
        run_instr(vt[0]);

        for (int i = 0; i < 200; i++) run_instr(rand_vec());

        ex_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("writes_outstanding", 96'(exp_q.size()), 96'(0));
        chk("mem_err_pulses", 96'(err_seen), 96'(err_exp));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
